// File: rtl/pc_gen.sv
// Program-counter generator: produces the fetch PC stream over a valid/ready handshake.
// Optional PC_MISALIGN_CHK_EN: aligns loaded targets and pulses misalign_err.
module pc_gen #(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     STEP       = 4,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int unsigned     ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign_err
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [XLEN-1:0] w_trap_tgt, w_redir_tgt;

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [XLEN-1:0] LO_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  logic r_err, w_err_nxt;
  logic w_trap_mis, w_redir_mis;

  assign w_trap_mis   = |(trap_vector & LO_MASK);
  assign w_redir_mis  = |(redirect_target & LO_MASK);
  assign w_trap_tgt   = trap_vector & ~LO_MASK;
  assign w_redir_tgt  = redirect_target & ~LO_MASK;
  assign misalign_err = r_err;
`else
  assign w_trap_tgt   = trap_vector;
  assign w_redir_tgt  = redirect_target;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
`ifdef PC_MISALIGN_CHK_EN
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        // A trap keeps the block running even when halt is requested.
        if (trap_valid) begin
          w_pc_nxt = w_trap_tgt;
`ifdef PC_MISALIGN_CHK_EN
          w_err_nxt = w_trap_mis;
`endif
        end else begin
          if (redirect_valid) begin
            w_pc_nxt = w_redir_tgt;
`ifdef PC_MISALIGN_CHK_EN
            w_err_nxt = w_redir_mis;
`endif
          end else if (pc_ready) begin
            w_pc_nxt = r_pc + XLEN'(STEP);
          end
          if (halt) w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        if (trap_valid) begin
          w_pc_nxt    = w_trap_tgt;
          w_state_nxt = S_RUN;
`ifdef PC_MISALIGN_CHK_EN
          w_err_nxt = w_trap_mis;
`endif
        end else if (!halt) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VEC;
`ifdef PC_MISALIGN_CHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
`ifdef PC_MISALIGN_CHK_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  assign pc       = r_pc;
  assign pc_valid = (r_state == S_RUN);
  assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: stimulus pushes expected per-cycle outputs, monitor pops and compares.
module tb_pc_gen;
  localparam int unsigned XLEN = 64;
  localparam logic [63:0] RV   = 64'h1000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_target = '0;
  logic            trap_valid = 1'b0;
  logic [XLEN-1:0] trap_vector = '0;
  logic            halt = 1'b0;
  logic            pc_ready = 1'b0;
  logic [XLEN-1:0] pc;
  logic            pc_valid, halted, misalign_err;

  pc_gen #(.XLEN(XLEN), .STEP(4), .RESET_VEC(RV), .ALIGN_BITS(2)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt(halt), .pc_ready(pc_ready),
    .pc(pc), .pc_valid(pc_valid), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic        vld;
    logic        hlt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 0;

  // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_mode = 0;
  logic [63:0] m_pc   = RV;
  logic        m_err  = 0;

  function automatic void m_load(input logic [63:0] t);
`ifdef PC_MISALIGN_CHK_EN
    m_err = (t % 4) != 0;
    m_pc  = t - (t % 4);
`else
    m_pc = t;
`endif
  endfunction

  task automatic cyc(input bit rst, input bit rv, input logic [63:0] rt,
                     input bit tv, input logic [63:0] tvec, input bit h, input bit rdy);
    exp_t e;
    @(negedge clk);
    reset = rst; redirect_valid = rv; redirect_target = rt;
    trap_valid = tv; trap_vector = tvec; halt = h; pc_ready = rdy;
    m_err = 0;
    if (rst) begin
      m_mode = 0; m_pc = RV;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (tv) m_load(tvec);
      else begin
        if (rv) m_load(rt);
        else if (rdy) m_pc = m_pc + 64'd4;
        if (h) m_mode = 2;
      end
    end else begin
      if (tv) begin m_load(tvec); m_mode = 1; end
      else if (!h) m_mode = 1;
    end
    e.pc = m_pc; e.vld = (m_mode == 1); e.hlt = (m_mode == 2); e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, rdy);
  endtask

  // Monitor: consumes one expectation per clock once stimulus is running.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (pc !== e.pc) begin
          failures++; $display("FAIL pc t=%0t got=%h exp=%h", $time, pc, e.pc);
        end
        if (pc_valid !== e.vld) begin
          failures++; $display("FAIL pc_valid t=%0t got=%b exp=%b", $time, pc_valid, e.vld);
        end
        if (halted !== e.hlt) begin
          failures++; $display("FAIL halted t=%0t got=%b exp=%b", $time, halted, e.hlt);
        end
        if (misalign_err !== e.err) begin
          failures++; $display("FAIL misalign_err t=%0t got=%b exp=%b", $time, misalign_err, e.err);
        end
      end
    end
  end

  initial begin
    logic [63:0] t;
    // Reset, boot, free-run, stall
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    idle(1, 3);
    idle(0, 3);
    idle(1, 2);
    // Trap beats redirect; lone redirect while stalled
    cyc(0, 1, 64'h2000, 1, 64'h80, 0, 1);
    cyc(0, 1, 64'h2000, 0, 0, 0, 0);
    idle(0, 1);
    // Wrap
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
    idle(1, 2);
    // Halt during accept, ignored redirect, trap wake, halt again, reset mid-halt
    cyc(0, 1, 64'h100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 1, 64'h3000, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 64'h40, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    idle(1, 2);
    // Halt with redirect in same cycle, then resume
    cyc(0, 1, 64'h500, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Misaligned targets
    cyc(0, 1, 64'h2002, 0, 0, 0, 0);
    idle(0, 2);
    cyc(0, 0, 0, 1, 64'h81, 0, 1);
    cyc(0, 1, 64'h2003, 1, 64'h84, 0, 1);
    idle(1, 2);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      t = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'(t[3:0]);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, t,
          $urandom_range(0, 19) == 0, {t[31:0], t[63:32]},
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    idle(1, 2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
